// File: rtl/prog_mem.sv
// prog_mem -- program/data memory on the CPU's shared tri-state bus, plus
// the boot sequencer that loads a program before releasing the CPU.
//
// After reset the block sits in LOAD. It holds the CPU in reset and accepts
// words from a host over a valid/ready port, writing them from address 0
// upward. The final word (ld_last, or the word at DEPTH-1) moves the block
// to RUN. One cycle later cpu_rst is released, so the CPU starts fetching
// from address 0. In RUN, reads are asynchronous and the memory drives
// data_bus only while the CPU is not writing. A ld_start pulse returns the
// block to LOAD at any time.
//
// Optional feature macro: MEM_PARITY_EN
//   When it is defined, each word stores an even-parity bit. parity_err is a
//   sticky flag that is set when the memory drives a word whose parity does
//   not match. When it is undefined, parity_err is tied to 0.
//
// Ports:
//   clk        in     system clock, all state on posedge
//   rst_n      in     asynchronous active-low reset
//   data_bus   inout  shared CPU data bus (MEM_WIDTH)
//   addr_bus   in     CPU address (WORD_SIZE)
//   wr_en      in     CPU write strobe, 1 = CPU drives data_bus
//   cpu_rst    out    active-high reset to the CPU
//   ld_start   in     1-cycle pulse: restart loading at address 0
//   ld_valid   in     load word present
//   ld_data    in     load word (MEM_WIDTH)
//   ld_last    in     marks the final load word
//   ld_ready   out    load word accepted when ld_valid & ld_ready
//   parity_err out    sticky parity error (MEM_PARITY_EN only, else 0)

module prog_mem #(
  parameter int MEM_WIDTH = 8,
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inout  wire  [MEM_WIDTH-1:0] data_bus,
  input  logic [WORD_SIZE-1:0] addr_bus,
  input  logic                 wr_en,
  output logic                 cpu_rst,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  input  logic [MEM_WIDTH-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic                 parity_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {LOAD, RUN} state_t;

  state_t               state;
  logic [AW-1:0]        ld_ptr;
  logic [MEM_WIDTH-1:0] mem [DEPTH];

  logic                 addr_ok;
  logic [AW-1:0]        mem_addr;
  logic                 drive;
  logic [MEM_WIDTH-1:0] rd_data;
  logic                 load_acc;
  logic [AW-1:0]        load_addr;
  logic                 load_end;
  logic                 cpu_wr;

  // Addresses at or above DEPTH do not exist. They read as 0 and writes to
  // them are dropped.
  assign addr_ok  = 32'(addr_bus) < 32'(DEPTH);
  assign mem_addr = addr_bus[AW-1:0];
  assign rd_data  = addr_ok ? mem[mem_addr] : '0;

  // The memory drives the bus only while the CPU is running and not writing.
  assign drive    = (state == RUN) && !cpu_rst && !wr_en;
  assign data_bus = drive ? rd_data : 'z;

  // A ld_start pulse redirects a word accepted on the same edge to address 0.
  // ld_start also overrides ld_last, so loading continues after that word.
  assign load_acc  = (state == LOAD) && ld_valid && ld_ready;
  assign load_addr = ld_start ? '0 : ld_ptr;
  assign load_end  = load_acc &&
                     ((ld_last && !ld_start) || (load_addr == AW'(DEPTH - 1)));
  assign cpu_wr    = (state == RUN) && wr_en && addr_ok;

  // The boot sequencer FSM. ld_ready is registered, so it first rises on the
  // first clock edge after reset is released. cpu_rst stays high through the
  // edge that enters RUN and falls on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      ld_ptr   <= '0;
      cpu_rst  <= 1'b1;
      ld_ready <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          cpu_rst <= 1'b1;
          if (load_end) begin
            state    <= RUN;
            ld_ready <= 1'b0;
            ld_ptr   <= load_addr;
          end else begin
            ld_ready <= 1'b1;
            ld_ptr   <= load_acc ? load_addr + AW'(1) : load_addr;
          end
        end
        RUN: begin
          if (ld_start) begin
            state    <= LOAD;
            ld_ptr   <= '0;
            cpu_rst  <= 1'b1;
            ld_ready <= 1'b1;
          end else begin
            cpu_rst  <= 1'b0;
            ld_ready <= 1'b0;
          end
        end
        default: begin
          state    <= LOAD;
          ld_ptr   <= '0;
          cpu_rst  <= 1'b1;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

  // Memory array. It is not reset, so contents survive rst_n. Load writes
  // and CPU writes cannot happen together because they belong to different
  // states.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      mem[load_addr] <= ld_data;
    end else if (cpu_wr) begin
      mem[mem_addr] <= data_bus;
    end
  end

`ifdef MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (load_acc) begin
      par_mem[load_addr] <= ^ld_data;
    end else if (cpu_wr) begin
      par_mem[mem_addr] <= ^data_bus;
    end
  end

  // Parity is checked only on words the memory actually puts on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (ld_start) begin
      parity_err <= 1'b0;
    end else if (drive && addr_ok && (par_mem[mem_addr] != ^rd_data)) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem -- directed self-checking bench for prog_mem.
// DEPTH is set to 200 so that out-of-range addresses can be reached on an
// 8-bit address bus.

module tb_prog_mem;

  localparam int MW = 8;
  localparam int WS = 8;
  localparam int DP = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  wire  [MW-1:0] data_bus;
  logic [WS-1:0] addr_bus;
  logic          wr_en;
  logic          cpu_rst;
  logic          ld_start;
  logic          ld_valid;
  logic [MW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          parity_err;
  logic [MW-1:0] cpu_drive;
  logic          cpu_oe;

  int checks = 0;
  int errors = 0;

  // Stands in for the CPU's data bus driver.
  assign data_bus = cpu_oe ? cpu_drive : 'z;

  prog_mem #(.MEM_WIDTH(MW), .WORD_SIZE(WS), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_bus   (data_bus),
    .addr_bus   (addr_bus),
    .wr_en      (wr_en),
    .cpu_rst    (cpu_rst),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [MW-1:0] data,
                               input logic last);
    ld_valid = valid;
    ld_data  = data;
    ld_last  = last;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic readCheck(input string tag, input logic [WS-1:0] addr,
                           input logic [MW-1:0] exp);
    addr_bus = addr;
    #1;
    checkOutput(tag, {24'b0, data_bus}, {24'b0, exp});
  endtask

  initial begin
    rst_n     = 1'b0;
    addr_bus  = '0;
    wr_en     = 1'b0;
    ld_start  = 1'b0;
    cpu_drive = '0;
    cpu_oe    = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Reset state.
    #12;
    checkOutput("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    checkOutput("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    checkOutput("rst_parity", {31'b0, parity_err}, 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("load_ready_up", {31'b0, ld_ready}, 32'd1);

    // The memory must not drive the bus during LOAD.
    cpu_oe = 1'b1; cpu_drive = 8'h3C;
    #1;
    checkOutput("load_bus_released", {24'b0, data_bus}, 32'h3C);
    cpu_oe = 1'b0;

    // Load a four-word program.
    applyStimulus(1'b1, 8'h01, 1'b0); tick();
    applyStimulus(1'b1, 8'h12, 1'b0); tick();
    applyStimulus(1'b1, 8'h34, 1'b0); tick();
    checkOutput("ready_before_last", {31'b0, ld_ready}, 32'd1);
    applyStimulus(1'b1, 8'h56, 1'b1); tick();
    checkOutput("ready_after_last", {31'b0, ld_ready}, 32'd0);
    checkOutput("cpu_rst_still_high", {31'b0, cpu_rst}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("cpu_rst_released", {31'b0, cpu_rst}, 32'd0);
    readCheck("read_a1", 8'd1, 8'h12);
    readCheck("read_a0", 8'd0, 8'h01);
    readCheck("read_a3", 8'd3, 8'h56);

    // CPU write of 0xA5 to address 3.
    addr_bus = 8'd3; wr_en = 1'b1; cpu_oe = 1'b1; cpu_drive = 8'hA5;
    #1;
    checkOutput("bus_during_write", {24'b0, data_bus}, 32'hA5);
    tick();
    wr_en = 1'b0; cpu_oe = 1'b0;
    readCheck("read_after_write", 8'd3, 8'hA5);
    readCheck("read_a2_untouched", 8'd2, 8'h34);

    // ld_start in RUN, load two words, then reset in the middle of the load.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    checkOutput("restart_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    checkOutput("restart_ready", {31'b0, ld_ready}, 32'd1);
    applyStimulus(1'b1, 8'hAA, 1'b0); tick();
    applyStimulus(1'b1, 8'hBB, 1'b0); tick();
    applyStimulus(1'b1, 8'hCC, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midload_rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    checkOutput("midload_rst_ready", {31'b0, ld_ready}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_ready", {31'b0, ld_ready}, 32'd1);
    applyStimulus(1'b1, 8'h77, 1'b1); tick();
    applyStimulus(1'b0, 8'h00, 1'b0); tick();
    checkOutput("reload_cpu_rst", {31'b0, cpu_rst}, 32'd0);
    readCheck("ptr_restart_a0", 8'd0, 8'h77);
    readCheck("persist_a1", 8'd1, 8'hBB);
    readCheck("cc_not_written_a2", 8'd2, 8'h34);

    // In LOAD, ld_start takes priority over ld_last.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    applyStimulus(1'b1, 8'h11, 1'b0); tick();
    applyStimulus(1'b1, 8'h22, 1'b0); tick();
    ld_start = 1'b1;
    applyStimulus(1'b1, 8'h33, 1'b1); tick();
    ld_start = 1'b0;
    checkOutput("start_beats_last", {31'b0, ld_ready}, 32'd1);
    applyStimulus(1'b1, 8'h44, 1'b1); tick();
    checkOutput("prio_end_ready", {31'b0, ld_ready}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0); tick();
    readCheck("prio_a0", 8'd0, 8'h33);
    readCheck("prio_a1", 8'd1, 8'h44);
    readCheck("prio_a2", 8'd2, 8'h34);
    readCheck("prio_a3", 8'd3, 8'hA5);

    // Full-depth load without ld_last. The load must stop at DEPTH-1.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < DP; i++) begin
      applyStimulus(1'b1, 8'(i + 128), 1'b0);
      tick();
    end
    checkOutput("full_ready_drop", {31'b0, ld_ready}, 32'd0);
    checkOutput("full_cpu_rst_high", {31'b0, cpu_rst}, 32'd1);
    applyStimulus(1'b1, 8'hEE, 1'b0);
    tick();
    checkOutput("full_cpu_rst_low", {31'b0, cpu_rst}, 32'd0);
    tick(); tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    readCheck("full_a0_no_wrap", 8'd0, 8'h80);
    readCheck("full_a2", 8'd2, 8'h82);
    readCheck("full_a199", 8'd199, 8'h47);

    // Out-of-range addresses.
    readCheck("oor_read_200", 8'd200, 8'h00);
    readCheck("oor_read_255", 8'd255, 8'h00);
    addr_bus = 8'd200; wr_en = 1'b1; cpu_oe = 1'b1; cpu_drive = 8'hFF;
    #1;
    checkOutput("oor_bus_during_write", {24'b0, data_bus}, 32'hFF);
    tick();
    wr_en = 1'b0; cpu_oe = 1'b0;
    readCheck("oor_read_after_write", 8'd200, 8'h00);
    readCheck("oor_a0_intact", 8'd0, 8'h80);
    readCheck("oor_a72_intact", 8'd72, 8'hC8);

`ifdef MEM_PARITY_EN
    // Corrupt one stored bit, then read that address.
    checkOutput("parity_clean", {31'b0, parity_err}, 32'd0);
    dut.mem[5] = dut.mem[5] ^ 8'h01;
    addr_bus = 8'd5;
    tick();
    checkOutput("parity_set", {31'b0, parity_err}, 32'd1);
    addr_bus = 8'd6;
    tick();
    checkOutput("parity_sticky", {31'b0, parity_err}, 32'd1);
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    checkOutput("parity_cleared", {31'b0, parity_err}, 32'd0);
`else
    checkOutput("parity_tied_low", {31'b0, parity_err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
